alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  2  per-requester command valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester command accept; one-hot or zero.
REQ-006 req_op0, req_op1  input  4 each  ALU opcode per requester: op[3] inverts a, op[2] inverts b and sets carry-in, op[1:0] selects 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-007 req_a0, req_b0, req_a1, req_b1  input  4 each  operands per requester.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  result consumer accept.
REQ-010 rsp_id  output  1  requester that owns the current result.
REQ-011 rsp_y  output  4  ALU result.
REQ-012 rsp_flags  output  4  {overflow, zero, neg, cout} from the ALU.

Function
REQ-013 FSM states SHALL be IDLE, EXEC and HOLD; reset state IDLE.
REQ-014 IDLE: no req_valid set -> stay IDLE, req_ready = 00.
REQ-015 IDLE: exactly one req_valid set -> grant that requester.
REQ-016 IDLE: both set -> grant the requester indicated by priority pointer prio (reset 0).
REQ-017 Grant: req_ready[grant] SHALL be 1 combinationally in that IDLE cycle only; op/a/b latched into command register at that edge; grant id latched; next state EXEC.
REQ-018 req_ready SHALL be 00 in EXEC and HOLD; a valid request never gets accepted outside IDLE.
REQ-019 EXEC: ALU driven only from command register; y and flags captured into response registers at end of cycle; next state HOLD.
REQ-020 HOLD: rsp_valid = 1; rsp_id/rsp_y/rsp_flags SHALL stay stable until rsp_ready sampled high.
REQ-021 HOLD with rsp_ready = 1: rsp_valid drops next cycle, prio set to ~granted id, next state IDLE.
REQ-022 Latency: accept at edge N -> rsp_valid high from cycle N+2; minimum 3 cycles per transaction.
REQ-023 Flags SHALL be exactly the ALU's: cout/neg/overflow forced 0 when op[1:0] != 11; zero = (y == 0); neg = ~cout & op[2] for ADD.
REQ-024 Requester dropping req_valid before grant: no effect, no state change.

Reset
REQ-025 Asynchronous assertion of rst_n SHALL immediately force state IDLE, prio 0, rsp_valid 0, rsp_id 0, rsp_y 0, rsp_flags 0, req_ready 00, command register 0.
REQ-026 Reset mid-EXEC or mid-HOLD SHALL discard the in-flight transaction with no response.
REQ-027 Deassertion: first grant possible on the first clock edge after rst_n high.

Configuration
REQ-028 Macro ALU_ARB_STICKY_OVF_EN SHALL, when defined, add input clr_sticky (1) and output sticky_ovf (1): sticky_ovf sets on every HOLD entry with overflow = 1, clears on clr_sticky = 1 (set wins on same cycle), resets to 0.
REQ-029 Without ALU_ARB_STICKY_OVF_EN those ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package alu_arb_pkg SHALL hold FSM state encoding, opcode field positions, op[1:0] function codes and the flag bit indices.
REQ-031 The block SHALL instantiate the existing alu module once as its only sub-module; no second ALU.

Verification
REQ-032 Req0 op=0011 a=3 b=4 -> rsp at accept+2: id=0, y=0111, flags=0000.
REQ-033 Req1 op=0111 a=5 b=5 -> y=0000, flags=0101 (zero, cout), neg=0.
REQ-034 Req0 op=0011 a=7 b=1 -> y=1000, flags=1000; with macro sticky_ovf=1 until clr_sticky pulse.
REQ-035 Both valid from reset, rsp_ready=1 -> grants 0,1,0,1 alternate; req_ready never 11.
REQ-036 rsp_ready held 0 for 5 cycles in HOLD -> rsp outputs stable, req_ready 00, no new accept.
REQ-037 rst_n asserted during EXEC -> rsp_valid 0 throughout, next grant goes to requester 0 when both valid.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding, opcode
// field layout, ALU function codes, flag bit positions and the command record.
package alu_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 4;
  localparam int OP_W    = 4;
  localparam int FLAG_W  = 4;

  // Opcode field positions
  localparam int OP_INV_A  = 3;
  localparam int OP_INV_B  = 2;
  localparam int OP_FN_LSB = 0;
  localparam int OP_FN_W   = 2;

  typedef enum logic [OP_FN_W-1:0] {
    FN_AND = 2'b00,
    FN_OR  = 2'b01,
    FN_XOR = 2'b10,
    FN_ADD = 2'b11
  } fn_t;

  // Flag vector is {overflow, zero, neg, cout}
  localparam int FLG_COUT = 0;
  localparam int FLG_NEG  = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_OVF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: optional operand inversion, AND/OR/XOR/ADD, and the
// {overflow, zero, neg, cout} flag vector. Arithmetic flags only for ADD.
module alu
  import alu_arb_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic [W-1:0]      y,
  output logic [FLAG_W-1:0] flags
);

  logic [W-1:0] a_x, b_x;
  logic         cin;
  logic [W:0]   sum;

  always_comb begin
    a_x   = op[OP_INV_A] ? ~a : a;
    b_x   = op[OP_INV_B] ? ~b : b;
    cin   = op[OP_INV_B];
    sum   = {1'b0, a_x} + {1'b0, b_x} + {{W{1'b0}}, cin};
    y     = '0;
    flags = '0;
    case (fn_t'(op[OP_FN_LSB +: OP_FN_W]))
      FN_AND: y = a_x & b_x;
      FN_OR:  y = a_x | b_x;
      FN_XOR: y = a_x ^ b_x;
      FN_ADD: begin
        y               = sum[W-1:0];
        flags[FLG_COUT] = sum[W];
        // neg reports "no carry out" on subtract-style ops (b inverted)
        flags[FLG_NEG]  = ~sum[W] & cin;
        flags[FLG_OVF]  = (a_x[W-1] == b_x[W-1]) && (sum[W-1] != a_x[W-1]);
      end
      default: y = '0;
    endcase
    flags[FLG_ZERO] = (y == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU: IDLE/EXEC/HOLD FSM,
// round-robin on contention. Optional sticky overflow: ALU_ARB_STICKY_OVF_EN.
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
`ifdef ALU_ARB_STICKY_OVF_EN
  input  logic                clr_sticky,
  output logic                sticky_ovf,
`endif
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  logic [OP_W-1:0]     req_op0,
  input  logic [OP_W-1:0]     req_op1,
  input  logic [DATA_W-1:0]   req_a0,
  input  logic [DATA_W-1:0]   req_b0,
  input  logic [DATA_W-1:0]   req_a1,
  input  logic [DATA_W-1:0]   req_b1,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_y,
  output logic [FLAG_W-1:0]   rsp_flags
);

  state_t state, state_nxt;
  logic   prio;
  logic   grant_any, grant_id, accept;
  logic   gnt_q;
  cmd_t   cmd_q;
  cmd_t   [NUM_REQ-1:0] req_cmd;

  logic [DATA_W-1:0] alu_y;
  logic [FLAG_W-1:0] alu_flags;

  assign req_cmd[0] = '{op: req_op0, a: req_a0, b: req_b0};
  assign req_cmd[1] = '{op: req_op1, a: req_a1, b: req_b1};

  always_comb begin
    grant_any = |req_valid;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = prio;
      default: grant_id = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: if (grant_any) begin
        accept    = 1'b1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_HOLD;
      ST_HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ready is gated by reset so nothing looks accepted while rst_n is low
  assign req_ready = (accept && rst_n) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      prio      <= 1'b0;
      cmd_q     <= '0;
      gnt_q     <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_flags <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q <= req_cmd[grant_id];
        gnt_q <= grant_id;
      end
      if (state == ST_EXEC) begin
        rsp_id    <= gnt_q;
        rsp_y     <= alu_y;
        rsp_flags <= alu_flags;
      end
      if (state == ST_HOLD && rsp_ready) prio <= ~rsp_id;
    end
  end

  alu #(.W(DATA_W)) u_alu (
    .op    (cmd_q.op),
    .a     (cmd_q.a),
    .b     (cmd_q.b),
    .y     (alu_y),
    .flags (alu_flags)
  );

`ifdef ALU_ARB_STICKY_OVF_EN
  // Set on entry to HOLD wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    sticky_ovf <= 1'b0;
    else if (state == ST_EXEC && alu_flags[FLG_OVF]) sticky_ovf <= 1'b1;
    else if (clr_sticky)                           sticky_ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, reset corner
// cases and randomized transactions against an arithmetic reference model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_ready;
  logic [3:0] req_op0, req_op1, req_a0, req_b0, req_a1, req_b1;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_y, rsp_flags;
`ifdef ALU_ARB_STICKY_OVF_EN
  logic       clr_sticky, sticky_ovf;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit m_prio;
  bit m_sticky;

  typedef struct {
    logic [1:0] v;
    logic [3:0] o0, a0, b0, o1, a1, b1;
    logic       id;
    logic [3:0] y, fl;
    int         stall;
  } vec_t;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ALU_ARB_STICKY_OVF_EN
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf),
`endif
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic; returns {flags, y}
  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    int ax, bx, c, s, sa, sb, ss, y;
    bit cout, ovf, neg, zero;
    ax = op[3] ? 15 - int'(a) : int'(a);
    bx = op[2] ? 15 - int'(b) : int'(b);
    c  = op[2] ? 1 : 0;
    cout = 0; ovf = 0; neg = 0;
    case (op[1:0])
      2'b00: y = ax & bx;
      2'b01: y = ax | bx;
      2'b10: y = ax ^ bx;
      default: begin
        s    = ax + bx + c;
        y    = s % 16;
        cout = (s > 15);
        sa   = (ax > 7) ? ax - 16 : ax;
        sb   = (bx > 7) ? bx - 16 : bx;
        ss   = sa + sb + c;
        ovf  = (ss > 7) || (ss < -8);
        neg  = !cout && (c == 1);
      end
    endcase
    zero = (y == 0);
    return {ovf, zero, neg, cout, 4'(y)};
  endfunction

  // Runs one transaction from IDLE; caller is positioned away from a clock edge.
  task automatic txn(input vec_t t, input string nm);
    logic [1:0] er;
    er = t.id ? 2'b10 : 2'b01;
    req_valid = t.v;
    req_op0 = t.o0; req_a0 = t.a0; req_b0 = t.b0;
    req_op1 = t.o1; req_a1 = t.a1; req_b1 = t.b1;
    rsp_ready = 1'b0;
    #1 chk({nm, "_grant"}, req_ready, er);
    @(posedge clk); #1;
    chk({nm, "_exec_ready"}, req_ready, 2'b00);
    chk({nm, "_exec_valid"}, rsp_valid, 1'b0);
    @(posedge clk); #1;
    m_sticky = m_sticky | t.fl[3];
    for (int i = 0; i <= t.stall; i++) begin
      chk({nm, "_valid"}, rsp_valid, 1'b1);
      chk({nm, "_id"}, rsp_id, t.id);
      chk({nm, "_y"}, rsp_y, t.y);
      chk({nm, "_flags"}, rsp_flags, t.fl);
      chk({nm, "_hold_ready"}, req_ready, 2'b00);
`ifdef ALU_ARB_STICKY_OVF_EN
      chk({nm, "_sticky"}, sticky_ovf, m_sticky);
`endif
      if (i < t.stall) begin @(posedge clk); #1; end
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({nm, "_done"}, rsp_valid, 1'b0);
    m_prio = ~t.id;
  endtask

  vec_t tbl[10];
  vec_t r;
  logic [7:0] ref_r;

  initial begin
    // {v, o0,a0,b0, o1,a1,b1, id, y, flags, stall}
    tbl[0] = '{2'b01, 4'b0011, 4'd3, 4'd4,   4'd0, 4'd0, 4'd0,       1'b0, 4'b0111, 4'b0000, 0};
    tbl[1] = '{2'b10, 4'd0, 4'd0, 4'd0,      4'b0111, 4'd5, 4'd5,    1'b1, 4'b0000, 4'b0101, 1};
    tbl[2] = '{2'b01, 4'b0011, 4'd7, 4'd1,   4'd0, 4'd0, 4'd0,       1'b0, 4'b1000, 4'b1000, 5};
    tbl[3] = '{2'b01, 4'b0000, 4'hC, 4'hA,   4'd0, 4'd0, 4'd0,       1'b0, 4'b1000, 4'b0000, 0};
    tbl[4] = '{2'b10, 4'd0, 4'd0, 4'd0,      4'b0001, 4'd0, 4'd0,    1'b1, 4'b0000, 4'b0100, 0};
    tbl[5] = '{2'b01, 4'b0010, 4'hF, 4'hF,   4'd0, 4'd0, 4'd0,       1'b0, 4'b0000, 4'b0100, 2};
    tbl[6] = '{2'b10, 4'd0, 4'd0, 4'd0,      4'b0111, 4'd3, 4'd5,    1'b1, 4'b1110, 4'b0010, 0};
    tbl[7] = '{2'b01, 4'b1011, 4'd0, 4'd1,   4'd0, 4'd0, 4'd0,       1'b0, 4'b0000, 4'b0101, 0};
    tbl[8] = '{2'b11, 4'b0000, 4'd0, 4'd0,   4'b0011, 4'd8, 4'd8,    1'b1, 4'b0000, 4'b1101, 0};
    tbl[9] = '{2'b11, 4'b0101, 4'd0, 4'hF,   4'b0011, 4'd1, 4'd1,    1'b0, 4'b0000, 4'b0100, 0};

    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = 2'b11;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
`ifdef ALU_ARB_STICKY_OVF_EN
    clr_sticky = 1'b0;
`endif
    m_prio = 1'b0; m_sticky = 1'b0;

    #12;
    chk("reset_ready", req_ready, 2'b00);
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_id", rsp_id, 1'b0);
    chk("reset_y", rsp_y, 4'd0);
    chk("reset_flags", rsp_flags, 4'd0);
    req_valid = 2'b00;
    #5 rst_n = 1'b1;

    // Contention from reset alternates 0,1,0,1
    for (int k = 0; k < 4; k++)
      txn('{2'b11, 4'b0011, 4'd1, 4'd1, 4'b0011, 4'd2, 4'd2, 1'(k % 2),
            (k % 2) ? 4'd4 : 4'd2, 4'b0000, 0}, $sformatf("alt%0d", k));

    for (int i = 0; i < 10; i++) txn(tbl[i], $sformatf("vec%0d", i));

`ifdef ALU_ARB_STICKY_OVF_EN
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    m_sticky = 1'b0;
    chk("sticky_clear", sticky_ovf, 1'b0);
`endif

    // Reset during EXEC: transaction dropped, prio back to 0
    txn('{2'b01, 4'b0011, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd1, 4'b0000, 0}, "pre_rst");
    req_valid = 2'b01; req_op0 = 4'b0011; req_a0 = 4'd7; req_b0 = 4'd7;
    #1 chk("abort_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1 chk("abort_valid0", rsp_valid, 1'b0);
    chk("abort_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    chk("abort_valid1", rsp_valid, 1'b0);
    chk("abort_y", rsp_y, 4'd0);
    rst_n = 1'b1; m_prio = 1'b0; m_sticky = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid2", rsp_valid, 1'b0);
    txn('{2'b11, 4'b0001, 4'd2, 4'd1, 4'b0001, 4'd4, 4'd8, 1'b0, 4'd3, 4'b0000, 0}, "post_rst");

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      r.v  = 2'($urandom_range(0, 3));
      r.o0 = 4'($urandom); r.a0 = 4'($urandom); r.b0 = 4'($urandom);
      r.o1 = 4'($urandom); r.a1 = 4'($urandom); r.b1 = 4'($urandom);
      r.stall = $urandom_range(0, 3);
      if (r.v == 2'b00) begin
        req_valid = 2'b00;
        #1 chk("rnd_idle_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        chk("rnd_idle_valid", rsp_valid, 1'b0);
      end else begin
        r.id  = (r.v == 2'b01) ? 1'b0 : (r.v == 2'b10) ? 1'b1 : m_prio;
        ref_r = r.id ? ref_alu(r.o1, r.a1, r.b1) : ref_alu(r.o0, r.a0, r.b0);
        r.y   = ref_r[3:0];
        r.fl  = ref_r[7:4];
        txn(r, $sformatf("rnd%0d", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
